// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the LEGv8 pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        ERROR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'hD503201F;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        valid;
    } if_id_t;

    // Word-aligned and the whole 4-byte word lies inside the ROM.
    function automatic logic is_legal(input logic [63:0] a, input logic [63:0] mem_size);
        return (a[1:0] == 2'b00) && ((a + 64'd3) < mem_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with hold / load-target / increment controls
//               and legality checks for the next sequential PC and the target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import cpu_pkg::*;
#(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        load,
    input  logic [63:0] load_pc,
    input  logic        inc,
    output logic [63:0] pc,
    output logic        next_legal,
    output logic        target_legal
);

    localparam logic [63:0] C_MEM_SIZE = 64'(MEM_SIZE);

    logic [63:0] r_pc;
    logic [63:0] w_pc_plus4;

    assign w_pc_plus4   = r_pc + 64'd4;
    assign next_legal   = is_legal(w_pc_plus4, C_MEM_SIZE);
    assign target_legal = is_legal(load_pc, C_MEM_SIZE);
    assign pc           = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (hold) begin
            r_pc <= r_pc;
        end else if (load) begin
            r_pc <= load_pc;
        end else if (inc) begin
            r_pc <= w_pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : LEGv8 instruction fetch: PC control, IF/ID register, halt /
//               error FSM and fetched-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [63:0]      redirect_pc,
    input  logic [31:0]      imem_instr,
    output logic [63:0]      imem_addr,
    output logic [31:0]      if_id_instr,
    output logic [63:0]      if_id_pc,
    output logic             if_id_valid,
    output logic             halted,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam if_id_t C_BUBBLE = '{instr: INSTR_NOP, pc: 64'h0, valid: 1'b0};

    fetch_state_e     r_state;
    if_id_t           r_if_id;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    logic             r_err;

    logic [63:0] w_pc;
    logic        w_next_legal;
    logic        w_target_legal;
    logic        w_load;
    logic        w_inc;
    logic        w_hold;

    // ERROR ignores redirects, so the PC only moves in FETCH/HALT.
    assign w_load = redirect && w_target_legal && (r_state != ERROR);
    assign w_inc  = (r_state == FETCH) && !redirect && !stall && w_next_legal;
    assign w_hold = !(w_load || w_inc);

    pc_reg #(
        .MEM_SIZE (MEM_SIZE),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .hold         (w_hold),
        .load         (w_load),
        .load_pc      (redirect_pc),
        .inc          (w_inc),
        .pc           (w_pc),
        .next_legal   (w_next_legal),
        .target_legal (w_target_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FETCH;
            r_if_id  <= C_BUBBLE;
            r_count  <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                FETCH, HALT: begin
                    if (redirect) begin
                        r_if_id  <= C_BUBBLE;
                        r_halted <= 1'b0;
                        if (w_target_legal) begin
                            r_state <= FETCH;
                        end else begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                        end
                    end else if (!stall) begin
                        if (r_state == FETCH) begin
                            r_if_id <= '{instr: imem_instr, pc: w_pc, valid: 1'b1};
                            r_count <= r_count + CNT_W'(1);
                            if (!w_next_legal) begin
                                r_state  <= HALT;
                                r_halted <= 1'b1;
                            end
                        end else begin
                            r_if_id <= C_BUBBLE;
                        end
                    end
                end
                ERROR: begin
                    r_if_id <= C_BUBBLE;
                end
                default: begin
                    r_state  <= ERROR;
                    r_if_id  <= C_BUBBLE;
                    r_halted <= 1'b0;
                    r_err    <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr   = w_pc;
    assign if_id_instr = r_if_id.instr;
    assign if_id_pc    = r_if_id.pc;
    assign if_id_valid = r_if_id.valid;
    assign halted      = r_halted;
    assign fetch_err   = r_err;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed scoreboard bench for fetch_stage with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [63:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] addr;
        logic        halted;
        logic        err;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];

    logic [31:0] rom [256];

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    fetch_stage #(
        .MEM_SIZE (1024),
        .RESET_PC (64'h0),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_instr  (imem_instr),
        .imem_addr   (imem_addr),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [63:0] pc, input logic [63:0] addr,
                                input logic h, input logic e, input logic [31:0] cnt);
        exp_t r;
        r.valid = v; r.pc = pc; r.addr = addr; r.halted = h; r.err = e; r.count = cnt;
        return r;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic st, input logic rd,
                        input logic [63:0] rpc, input exp_t e);
        exp_t x;
        logic [31:0] exp_instr;
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        exp_instr = x.valid ? rom[x.pc[9:2]] : INSTR_NOP;
        chk({tag, ".valid"},  64'(if_id_valid), 64'(x.valid));
        chk({tag, ".instr"},  64'(if_id_instr), 64'(exp_instr));
        if (x.valid) chk({tag, ".pc"}, if_id_pc, x.pc);
        chk({tag, ".addr"},   imem_addr, x.addr);
        chk({tag, ".halted"}, 64'(halted), 64'(x.halted));
        chk({tag, ".err"},    64'(fetch_err), 64'(x.err));
        chk({tag, ".count"},  64'(fetch_count), 64'(x.count));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC000_0000 | 32'(i);
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;

        // Reset state
        step("reset", 1, 0, 0, 0, mk(0, 0, 64'h0, 0, 0, 0));
        chk("reset.if_id_pc", if_id_pc, 64'h0);

        // Sequential fetch
        step("seq0", 0, 0, 0, 0, mk(1, 64'h0, 64'h4, 0, 0, 1));
        step("seq1", 0, 0, 0, 0, mk(1, 64'h4, 64'h8, 0, 0, 2));

        // Stall holds PC, IF/ID and count
        step("stall0", 0, 1, 0, 0, mk(1, 64'h4, 64'h8, 0, 0, 2));
        step("stall1", 0, 1, 0, 0, mk(1, 64'h4, 64'h8, 0, 0, 2));
        step("seq2",   0, 0, 0, 0, mk(1, 64'h8, 64'hC, 0, 0, 3));

        // Redirect wins over simultaneous stall
        step("rdst",  0, 1, 1, 64'h40, mk(0, 0, 64'h40, 0, 0, 3));
        step("rd40",  0, 0, 0, 0,      mk(1, 64'h40, 64'h44, 0, 0, 4));

        // End of ROM
        step("rd3f0", 0, 0, 1, 64'h3F0, mk(0, 0, 64'h3F0, 0, 0, 4));
        step("e3f0",  0, 0, 0, 0, mk(1, 64'h3F0, 64'h3F4, 0, 0, 5));
        step("e3f4",  0, 0, 0, 0, mk(1, 64'h3F4, 64'h3F8, 0, 0, 6));
        step("e3f8",  0, 0, 0, 0, mk(1, 64'h3F8, 64'h3FC, 0, 0, 7));
        step("e3fc",  0, 0, 0, 0, mk(1, 64'h3FC, 64'h3FC, 1, 0, 8));
        step("halt0", 0, 0, 0, 0, mk(0, 0, 64'h3FC, 1, 0, 8));
        step("halt1", 0, 1, 0, 0, mk(0, 0, 64'h3FC, 1, 0, 8));
        step("rd10",  0, 0, 1, 64'h10, mk(0, 0, 64'h10, 0, 0, 8));
        step("f10",   0, 0, 0, 0, mk(1, 64'h10, 64'h14, 0, 0, 9));

        // Misaligned target
        step("bad42", 0, 0, 1, 64'h42, mk(0, 0, 64'h14, 0, 1, 9));
        step("err0",  0, 0, 0, 0,      mk(0, 0, 64'h14, 0, 1, 9));
        step("errrd", 0, 0, 1, 64'h18, mk(0, 0, 64'h14, 0, 1, 9));
        step("errst", 0, 1, 0, 0,      mk(0, 0, 64'h14, 0, 1, 9));
        step("rst2",  1, 0, 0, 0,      mk(0, 0, 64'h0, 0, 0, 0));

        // Out-of-range target
        step("f0",     0, 0, 0, 0,       mk(1, 64'h0, 64'h4, 0, 0, 1));
        step("bad400", 0, 0, 1, 64'h400, mk(0, 0, 64'h4, 0, 1, 1));
        step("rst3",   1, 0, 0, 0,       mk(0, 0, 64'h0, 0, 0, 0));

        // Reset during stall at pc=0x20
        step("f0b",   0, 0, 0, 0,      mk(1, 64'h0, 64'h4, 0, 0, 1));
        step("rd20",  0, 0, 1, 64'h20, mk(0, 0, 64'h20, 0, 0, 1));
        step("st20",  0, 1, 0, 0,      mk(0, 0, 64'h20, 0, 0, 1));
        step("rstst", 1, 1, 0, 0,      mk(0, 0, 64'h0, 0, 0, 0));
        step("post",  0, 0, 0, 0,      mk(1, 64'h0, 64'h4, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
